// File: rtl/neuron_input_feeder.sv
// Front-end sequencer for one adder_compare neuron: collects 9 activations plus a bias,
// issues them as a parallel frame, waits the neuron latency and returns the decision.
module neuron_input_feeder #(
    parameter int N_IN       = 9,
    parameter int DATA_W     = 12,
    parameter int BIAS_W     = 13,
    parameter int RESULT_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [BIAS_W-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [DATA_W-1:0] input_array_0,
    output logic [DATA_W-1:0] input_array_1,
    output logic [DATA_W-1:0] input_array_2,
    output logic [DATA_W-1:0] input_array_3,
    output logic [DATA_W-1:0] input_array_4,
    output logic [DATA_W-1:0] input_array_5,
    output logic [DATA_W-1:0] input_array_6,
    output logic [DATA_W-1:0] input_array_7,
    output logic [DATA_W-1:0] input_array_8,
    output logic [BIAS_W-1:0] bias,
    output logic              nc_valid,
    input  logic              nc_out,
    output logic              r_data,
    output logic              r_valid,
    input  logic              r_ready,
    output logic              busy,
    output logic [15:0]       frame_cnt
);

    typedef enum logic [1:0] {
        S_LOAD,
        S_ISSUE,
        S_WAIT,
        S_RESULT
    } state_e;

    localparam logic [3:0] IDX_BIAS = 4'(N_IN);
    localparam logic [3:0] LAT      = 4'(RESULT_LAT);

    state_e            state_q, state_d;
    logic [3:0]        idx_q, idx_d;
    logic [3:0]        wait_cnt_q, wait_cnt_d;
    logic [DATA_W-1:0] act_q [N_IN];
    logic [DATA_W-1:0] act_d [N_IN];
    logic [BIAS_W-1:0] bias_q, bias_d;
    logic              r_data_q, r_data_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;

    assign s_ready = (state_q == S_LOAD) && rst;

    always_comb begin
        // NOTE: every next-state value takes its current value first, so no path can infer a latch.
        state_d     = state_q;
        idx_d       = idx_q;
        wait_cnt_d  = wait_cnt_q;
        act_d       = act_q;
        bias_d      = bias_q;
        r_data_d    = r_data_q;
        frame_cnt_d = frame_cnt_q;

        case (state_q)
            S_LOAD: begin
                if (s_valid && s_ready) begin
                    if (idx_q == IDX_BIAS) begin
                        bias_d  = s_data;
                        idx_d   = 4'd0;
                        state_d = S_ISSUE;
                    end else begin
                        act_d[idx_q] = s_data[DATA_W-1:0];
                        idx_d        = idx_q + 4'd1;
                    end
                end
            end
            S_ISSUE: begin
                wait_cnt_d = LAT;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                wait_cnt_d = wait_cnt_q - 4'd1;
                if (wait_cnt_q == 4'd1) begin
                    r_data_d = nc_out;
                    state_d  = S_RESULT;
                end
            end
            S_RESULT: begin
                if (r_ready) begin
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = S_LOAD;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_LOAD;
            idx_q       <= 4'd0;
            wait_cnt_q  <= 4'd0;
            // NOTE: the activation registers drive the neuron directly, so they are reset like any other output.
            for (int i = 0; i < N_IN; i++) act_q[i] <= '0;
            bias_q      <= '0;
            r_data_q    <= 1'b0;
            frame_cnt_q <= 16'd0;
        end else begin
            // NOTE: non-blocking assignments make all registers update together from pre-edge values.
            state_q     <= state_d;
            idx_q       <= idx_d;
            wait_cnt_q  <= wait_cnt_d;
            act_q       <= act_d;
            bias_q      <= bias_d;
            r_data_q    <= r_data_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign input_array_0 = act_q[0];
    assign input_array_1 = act_q[1];
    assign input_array_2 = act_q[2];
    assign input_array_3 = act_q[3];
    assign input_array_4 = act_q[4];
    assign input_array_5 = act_q[5];
    assign input_array_6 = act_q[6];
    assign input_array_7 = act_q[7];
    assign input_array_8 = act_q[8];
    assign bias          = bias_q;
    assign nc_valid      = (state_q == S_ISSUE);
    assign r_valid       = (state_q == S_RESULT);
    assign r_data        = r_data_q;
    assign busy          = (state_q != S_LOAD);
    assign frame_cnt     = frame_cnt_q;

endmodule

// File: tb/tb_neuron_input_feeder.sv
// Self-checking bench for neuron_input_feeder: a registered sum>=bias stub stands in for
// the neuron, and a frame-level model predicts bus contents, decisions and frame count.
module tb_neuron_input_feeder;

    localparam int LAT = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [12:0] s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [11:0] input_array_0, input_array_1, input_array_2, input_array_3, input_array_4;
    logic [11:0] input_array_5, input_array_6, input_array_7, input_array_8;
    logic [12:0] bias;
    logic        nc_valid;
    logic        nc_out = 1'b0;
    logic        r_data;
    logic        r_valid;
    logic        r_ready = 1'b0;
    logic        busy;
    logic [15:0] frame_cnt;

    int checks   = 0;
    int failures = 0;

    logic [11:0] exp_act [9];
    logic [12:0] exp_bias;
    logic [15:0] exp_frames;
    logic [12:0] words [10];
    logic [11:0] bus [9];

    neuron_input_feeder #(
        .N_IN(9), .DATA_W(12), .BIAS_W(13), .RESULT_LAT(LAT)
    ) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .input_array_0(input_array_0), .input_array_1(input_array_1),
        .input_array_2(input_array_2), .input_array_3(input_array_3),
        .input_array_4(input_array_4), .input_array_5(input_array_5),
        .input_array_6(input_array_6), .input_array_7(input_array_7),
        .input_array_8(input_array_8),
        .bias(bias), .nc_valid(nc_valid), .nc_out(nc_out),
        .r_data(r_data), .r_valid(r_valid), .r_ready(r_ready),
        .busy(busy), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    always_comb begin
        bus[0] = input_array_0; bus[1] = input_array_1; bus[2] = input_array_2;
        bus[3] = input_array_3; bus[4] = input_array_4; bus[5] = input_array_5;
        bus[6] = input_array_6; bus[7] = input_array_7; bus[8] = input_array_8;
    end

    // Neuron stand-in: unsigned 16-bit sum of the activations compared to the bias, one register deep.
    always @(posedge clk) begin
        nc_out <= (16'(input_array_0) + 16'(input_array_1) + 16'(input_array_2)
                 + 16'(input_array_3) + 16'(input_array_4) + 16'(input_array_5)
                 + 16'(input_array_6) + 16'(input_array_7) + 16'(input_array_8)) >= 16'(bias);
    end

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_bus(input string tag);
        for (int k = 0; k < 9; k++) check($sformatf("%s_act%0d", tag, k), 32'(bus[k]), 32'(exp_act[k]));
        check({tag, "_bias"}, 32'(bias), 32'(exp_bias));
    endtask

    task automatic model_reset();
        for (int k = 0; k < 9; k++) exp_act[k] = '0;
        exp_bias   = '0;
        exp_frames = '0;
    endtask

    task automatic send_word(input logic [12:0] w);
        int n = 0;
        s_data  = w;
        s_valid = 1'b1;
        while (!s_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("s_ready_wait", 32'(s_ready), 32'd1);
        @(negedge clk);
        s_valid = 1'b0;
    endtask

    task automatic send_frame(input int max_gap, input bit check_each);
        for (int k = 0; k < 10; k++) begin
            int gap = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            repeat (gap) @(negedge clk);
            send_word(words[k]);
            if (k < 9) exp_act[k] = words[k][11:0];
            else       exp_bias   = words[k];
            if (check_each) check_bus("load");
        end
    endtask

    // Called on the falling edge right after the bias transfer; junk is offered while busy.
    task automatic finish_frame(input int hold);
        int   sum = 0;
        logic exp_dec;
        for (int k = 0; k < 9; k++) sum += int'(exp_act[k]);
        exp_dec = (sum >= int'(exp_bias));
        r_ready = (hold == 0);
        s_valid = 1'b1;
        s_data  = 13'h1FFF;
        check("issue_nc_valid", 32'(nc_valid), 32'd1);
        check("issue_busy", 32'(busy), 32'd1);
        check("issue_s_ready", 32'(s_ready), 32'd0);
        for (int i = 0; i < LAT; i++) begin
            @(negedge clk);
            check("wait_nc_valid", 32'(nc_valid), 32'd0);
            check("wait_r_valid", 32'(r_valid), 32'd0);
        end
        @(negedge clk);
        check("result_r_valid", 32'(r_valid), 32'd1);
        check("result_r_data", 32'(r_data), 32'(exp_dec));
        check_bus("result");
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_r_valid", 32'(r_valid), 32'd1);
            check("hold_r_data", 32'(r_data), 32'(exp_dec));
            check("hold_s_ready", 32'(s_ready), 32'd0);
            check_bus("hold");
        end
        r_ready = 1'b1;
        @(negedge clk);
        s_valid = 1'b0;
        exp_frames = exp_frames + 16'd1;
        check("done_r_valid", 32'(r_valid), 32'd0);
        check("done_busy", 32'(busy), 32'd0);
        check("done_s_ready", 32'(s_ready), 32'd1);
        check("done_frame_cnt", 32'(frame_cnt), 32'(exp_frames));
        check_bus("done");
    endtask

    task automatic fill_const(input logic [12:0] act, input logic [12:0] b);
        for (int k = 0; k < 9; k++) words[k] = act;
        words[9] = b;
    endtask

    initial begin
        model_reset();

        // Reset with a pending word: nothing may be accepted, everything reads zero.
        s_valid = 1'b1;
        s_data  = 13'h0ABC;
        repeat (2) @(negedge clk);
        check("rst_s_ready", 32'(s_ready), 32'd0);
        check("rst_nc_valid", 32'(nc_valid), 32'd0);
        check("rst_r_valid", 32'(r_valid), 32'd0);
        check("rst_r_data", 32'(r_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        check_bus("rst");
        rst     = 1'b1;
        s_valid = 1'b0;
        @(negedge clk);
        check("post_rst_s_ready", 32'(s_ready), 32'd1);
        check("post_rst_busy", 32'(busy), 32'd0);

        // Back-to-back frame, consumer always ready.
        fill_const(13'h200, 13'h400);
        send_frame(0, 1'b0);
        finish_frame(0);

        // Two frames straddling the threshold.
        fill_const(13'h19A, 13'h5CC);
        send_frame(0, 1'b0);
        finish_frame(0);
        fill_const(13'h099, 13'h5CC);
        send_frame(0, 1'b0);
        finish_frame(0);

        // Result backpressure.
        fill_const(13'h123, 13'h0FF);
        send_frame(0, 1'b0);
        finish_frame(5);

        // Random words with bit 12 set at random, random gaps and random backpressure.
        for (int f = 0; f < 6; f++) begin
            for (int k = 0; k < 9; k++) words[k] = {1'($urandom), 12'($urandom_range(0, 1023))};
            words[9] = 13'($urandom);
            send_frame(2, 1'b1);
            finish_frame(int'($urandom_range(0, 2)));
        end

        // Reset part-way through a frame, then a full frame must load from index 0.
        for (int k = 0; k < 5; k++) begin
            words[k] = 13'($urandom);
            send_word(words[k]);
            exp_act[k] = words[k][11:0];
        end
        check_bus("partial");
        rst = 1'b0;
        #1;
        model_reset();
        check("midrst_s_ready", 32'(s_ready), 32'd0);
        check("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
        check_bus("midrst");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        fill_const(13'h100, 13'h900);
        send_frame(0, 1'b0);
        finish_frame(0);

        // Frame counter wrap.
        force dut.frame_cnt_q = 16'hFFFF;
        @(negedge clk);
        release dut.frame_cnt_q;
        exp_frames = 16'hFFFF;
        @(negedge clk);
        check("preset_frame_cnt", 32'(frame_cnt), 32'(exp_frames));
        fill_const(13'h001, 13'h00A);
        send_frame(1, 1'b0);
        finish_frame(1);
        check("wrap_frame_cnt", 32'(frame_cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
